spi_adc_poller: RTL and testbench
=================================

Name: spi_adc_poller

Overview:
- Transaction sequencer directly upstream of the SPI byte master; drives its byte interface (TX byte/valid, TX ready, RX byte/valid) and owns chip select.
- Continuously sweeps c_NUM_CHANNELS single-ended channels of an MCP3008-class 10-bit ADC (joystick axes, triggers).
- Publishes each result with its channel number as a one-cycle valid pulse to the input-mapping logic.

Parameters:
- c_NUM_CHANNELS, 2, channels polled per sweep, ch 0..N-1; legal 1-8.
- c_POLL_CLKS, 50000, idle clocks between end of one sweep and start of the next; legal >=1.
- c_CS_GAP_CLKS, 4, clocks CS_n is held low before the first byte, and held low after the last RX byte before release; also the minimum CS_n-high time between transactions; legal >=1.

Ports:
- i_CLK  in  1  system clock (same domain as SPI master)
- i_RESET  in  1  reset; one clock; reset is asynchronous and active-high
- i_ENABLE  in  1  level; 1 = run sweeps, 0 = stop at next transaction boundary
- o_TX_BYTE  out  8  byte to SPI master
- o_TX_DV  out  1  one-cycle strobe, byte valid to SPI master
- i_TX_READY  in  1  SPI master idle and able to accept a byte
- i_RX_DV  in  1  one-cycle strobe, i_RX_BYTE valid
- i_RX_BYTE  in  8  byte shifted in from MISO
- o_SPI_CS_n  out  1  ADC chip select, active low
- o_SAMPLE  out  10  conversion result
- o_SAMPLE_CH  out  3  channel of o_SAMPLE
- o_SAMPLE_DV  out  1  one-cycle strobe, o_SAMPLE/o_SAMPLE_CH valid
- o_BUSY  out  1  1 while CS_n low or in a transaction state

Behaviour:
- Reset values (async, immediate): o_SPI_CS_n=1, o_TX_DV=0, o_TX_BYTE=0, o_SAMPLE=0, o_SAMPLE_CH=0, o_SAMPLE_DV=0, o_BUSY=0; FSM=IDLE; channel=0; all counters=0.
- Reset mid-transaction aborts immediately. CS_n rises asynchronously. Any byte still in the SPI master is discarded by this block.
- Transaction = 3 bytes, CS_n low throughout: 0x01, {1'b1, ch[2:0], 4'b0000}, 0x00.
  - ch0 second byte = 0x80; ch1 second byte = 0x90.
- Result = {RX byte 2 [1:0], RX byte 3 [7:0]}. RX byte 1 and RX byte 2 [7:2] are ignored.
- FSM states:
  - IDLE: CS_n=1. If i_ENABLE=1, channel=0 and go to CS_SETUP.
  - CS_SETUP: CS_n=0; count c_CS_GAP_CLKS, then go to SEND.
  - SEND: wait for i_TX_READY=1. Then drive o_TX_BYTE and pulse o_TX_DV for exactly one cycle; go to WAIT_RX.
  - WAIT_RX: wait for i_RX_DV and capture i_RX_BYTE. If byte index < 2, increment index and go to SEND; else go to CS_HOLD.
  - CS_HOLD: count c_CS_GAP_CLKS, then CS_n=1 and go to PUBLISH.
  - PUBLISH: o_SAMPLE_DV=1 for one cycle. Then:
    - channel < N-1 and i_ENABLE=1: channel+1, go to CS_GAP.
    - channel = N-1: channel=0, go to POLL_WAIT.
    - i_ENABLE=0: go to IDLE.
  - CS_GAP: CS_n=1 for c_CS_GAP_CLKS, then go to CS_SETUP.
  - POLL_WAIT: count c_POLL_CLKS. Return to IDLE early if i_ENABLE drops. At terminal count go to CS_SETUP if i_ENABLE=1, else IDLE.
- o_TX_DV is never asserted while i_TX_READY=0 or while CS_n=1. Max one TX_DV outstanding per RX_DV.
- i_RX_DV outside WAIT_RX is ignored and causes no state change.
- i_ENABLE falling mid-transaction does not truncate it; the transaction completes and is published.
- Latency, TX_READY constant 1: CS_n fall to first o_TX_DV = c_CS_GAP_CLKS+1 clocks. Final RX_DV to o_SAMPLE_DV = c_CS_GAP_CLKS+1 clocks.
- o_SAMPLE and o_SAMPLE_CH are registered and hold their value until the next PUBLISH.

Optional Feature:
- Macro: SPI_ADC_POLLER_AVG_EN.
- Defined:
  - Each channel gets 4 back-to-back transactions, each with the full CS framing and CS_GAP between them.
  - Results accumulate in a 12-bit sum; o_SAMPLE = sum[11:2] (truncating).
  - One o_SAMPLE_DV per channel, after the 4th transaction.
  - The accumulator clears at each channel start.
  - i_ENABLE falling mid-group finishes all 4 transactions.
- Undefined: one transaction per channel as above; no accumulator logic is synthesized.

Test Plan:
- Reset in mid-byte 2 of ch0 -> CS_n=1 same cycle, no o_SAMPLE_DV. After release with i_ENABLE=1, a fresh transaction starts at byte 0x01.
- N=2, TX_READY=1, stub returns ch0 bytes 0xFF,0xFE,0x5A and ch1 bytes 0x00,0x01,0x33:
  - TX sequence is 0x01,0x80,0x00,0x01,0x90,0x00.
  - Outputs are SAMPLE=0x25A CH=0, then SAMPLE=0x133 CH=1.
  - Exactly 2 SAMPLE_DV pulses, then c_POLL_CLKS idle.
- Hold i_TX_READY=0 for 20 clocks in SEND -> o_TX_DV stays 0, CS_n stays 0. TX_DV fires the cycle TX_READY returns to 1.
- Drop i_ENABLE after byte 1 of ch0 -> ch0 completes and publishes, CS_n=1, FSM IDLE, no ch1 transaction.
- Inject i_RX_DV during CS_SETUP and POLL_WAIT -> no capture, no state change; next sample still correct.
- With SPI_ADC_POLLER_AVG_EN, ch0 results 0x100,0x101,0x102,0x103 -> one SAMPLE_DV with SAMPLE=0x101; 4 CS_n low pulses.

Source files
------------

// File: rtl/spi_adc_poller_if.sv
// spi_adc_poller_if: the poller's byte-level SPI master link, its chip
// select and its published result, bundled as one interface.
//   master : the poller (drives TX byte/strobe, CS_n and the sample outputs)
//   slave  : whoever sits across from it (SPI byte master + input mapping)
//
// Signals:
//   enable     level, run sweeps
//   tx_byte    byte for the SPI master;   tx_dv     one-cycle strobe
//   tx_ready   SPI master idle
//   rx_byte    byte shifted in from MISO; rx_dv     one-cycle strobe
//   spi_cs_n   ADC chip select, active low
//   sample     10-bit result; sample_ch its channel; sample_dv strobe
//   busy       transaction in progress or CS_n low
interface spi_adc_poller_if;
  logic       enable;
  logic [7:0] tx_byte;
  logic       tx_dv;
  logic       tx_ready;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       spi_cs_n;
  logic [9:0] sample;
  logic [2:0] sample_ch;
  logic       sample_dv;
  logic       busy;

  modport master (
    input  enable, tx_ready, rx_dv, rx_byte,
    output tx_byte, tx_dv, spi_cs_n, sample, sample_ch, sample_dv, busy
  );

  modport slave (
    output enable, tx_ready, rx_dv, rx_byte,
    input  tx_byte, tx_dv, spi_cs_n, sample, sample_ch, sample_dv, busy
  );
endinterface

// File: rtl/spi_adc_poller.sv
// spi_adc_poller: sweeps channels 0..c_NUM_CHANNELS-1 of an MCP3008-class
// 10-bit ADC through an SPI byte master. Each conversion is a 3-byte frame
// (0x01, {1,ch,0000}, 0x00) under one CS_n low window; the result
// {rx2[1:0], rx3} is published with its channel as a one-cycle strobe.
//
// Ports:
//   clk   system clock (same domain as the SPI byte master)
//   rst   asynchronous active-high reset; aborts any frame, CS_n rises at once
//   bus   spi_adc_poller_if.master (see interface file for signal list)
//
// Optional feature (macro SPI_ADC_POLLER_AVG_EN): each channel is converted
// 4 times back to back, summed in 12 bits, and sum[11:2] is published once.
module spi_adc_poller #(
  parameter int c_NUM_CHANNELS = 2,
  parameter int c_POLL_CLKS    = 50000,
  parameter int c_CS_GAP_CLKS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_adc_poller_if.master  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CS_SETUP  = 3'd1;
  localparam logic [2:0] S_SEND      = 3'd2;
  localparam logic [2:0] S_WAIT_RX   = 3'd3;
  localparam logic [2:0] S_CS_HOLD   = 3'd4;
  localparam logic [2:0] S_PUBLISH   = 3'd5;
  localparam logic [2:0] S_CS_GAP    = 3'd6;
  localparam logic [2:0] S_POLL_WAIT = 3'd7;

  localparam logic [2:0]  LAST_CH   = 3'(c_NUM_CHANNELS - 1);
  localparam logic [31:0] GAP_LAST  = 32'(c_CS_GAP_CLKS - 1);
  localparam logic [31:0] SETUP_END = 32'(c_CS_GAP_CLKS);
  localparam logic [31:0] POLL_LAST = 32'(c_POLL_CLKS - 1);

  logic [2:0]  state;
  logic [31:0] cnt;
  logic [2:0]  ch;
  logic [1:0]  idx;
  logic [1:0]  res_hi;
  logic        cs_n;
  logic [9:0]  sample;
  logic [2:0]  sample_ch;
  logic        sample_dv;
  logic [7:0]  byte_sel;
  logic [9:0]  res_new;
  logic        group_done;

  assign res_new = {res_hi, bus.rx_byte};

`ifdef SPI_ADC_POLLER_AVG_EN
  logic [1:0]  rep;
  logic [11:0] acc;
  assign group_done = (rep == 2'd3);
`else
  logic [9:0]  res;
  assign group_done = 1'b1;
`endif

  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      2'd0:    byte_sel = 8'h01;
      2'd1:    byte_sel = {1'b1, ch, 4'b0000};
      default: byte_sel = 8'h00;
    endcase
  end

  // Strobe is combinational so it goes out in the very cycle TX ready is seen.
  assign bus.tx_dv     = (state == S_SEND) && bus.tx_ready && !cs_n;
  assign bus.tx_byte   = (state == S_SEND) ? byte_sel : 8'h00;
  assign bus.spi_cs_n  = cs_n;
  assign bus.sample    = sample;
  assign bus.sample_ch = sample_ch;
  assign bus.sample_dv = sample_dv;
  assign bus.busy      = (state != S_IDLE) && (state != S_POLL_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ch        <= '0;
      idx       <= '0;
      res_hi    <= '0;
      cs_n      <= 1'b1;
      sample    <= '0;
      sample_ch <= '0;
      sample_dv <= 1'b0;
`ifdef SPI_ADC_POLLER_AVG_EN
      rep       <= '0;
      acc       <= '0;
`else
      res       <= '0;
`endif
    end else begin
      sample_dv <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.enable) begin
            ch    <= '0;
            cnt   <= '0;
            cs_n  <= 1'b0;
            state <= S_CS_SETUP;
`ifdef SPI_ADC_POLLER_AVG_EN
            rep   <= '0;
`endif
          end
        end
        // Counts 0..G: CS_n is low G+1 clocks before the first strobe.
        S_CS_SETUP: begin
          if (cnt == SETUP_END) begin
            cnt   <= '0;
            idx   <= '0;
            state <= S_SEND;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_SEND: begin
          if (bus.tx_ready) state <= S_WAIT_RX;
        end
        S_WAIT_RX: begin
          if (bus.rx_dv) begin
            if (idx == 2'd1) res_hi <= bus.rx_byte[1:0];
            if (idx == 2'd2) begin
`ifdef SPI_ADC_POLLER_AVG_EN
              acc <= ((rep == 2'd0) ? 12'd0 : acc) + 12'(res_new);
`else
              res <= res_new;
`endif
              cnt   <= '0;
              state <= S_CS_HOLD;
            end else begin
              idx   <= idx + 2'd1;
              state <= S_SEND;
            end
          end
        end
        S_CS_HOLD: begin
          if (cnt == GAP_LAST) begin
            cnt  <= '0;
            cs_n <= 1'b1;
            if (group_done) begin
`ifdef SPI_ADC_POLLER_AVG_EN
              sample <= acc[11:2];
`else
              sample <= res;
`endif
              sample_ch <= ch;
              sample_dv <= 1'b1;
              state     <= S_PUBLISH;
            end else begin
`ifdef SPI_ADC_POLLER_AVG_EN
              rep <= rep + 2'd1;
`endif
              // more conversions of this channel: enable is not consulted
              state <= S_CS_GAP;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_PUBLISH: begin
          cnt <= '0;
`ifdef SPI_ADC_POLLER_AVG_EN
          rep <= '0;
`endif
          if (ch == LAST_CH) begin
            ch    <= '0;
            state <= S_POLL_WAIT;
          end else if (bus.enable) begin
            ch    <= ch + 3'd1;
            state <= S_CS_GAP;
          end else begin
            ch    <= '0;
            state <= S_IDLE;
          end
        end
        S_CS_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            cs_n  <= 1'b0;
            state <= S_CS_SETUP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_POLL_WAIT: begin
          if (!bus.enable) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == POLL_LAST) begin
            cnt   <= '0;
            cs_n  <= 1'b0;
            state <= S_CS_SETUP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_poller.sv
// tb_spi_adc_poller: scoreboard bench for spi_adc_poller. Stimulus pushes
// expected TX bytes and samples into queues; a monitor pops and compares on
// every tx_dv / sample_dv. An SPI stub answers each TX byte with an RX byte.
module tb_spi_adc_poller;
  localparam int N = 2;
  localparam int P = 20;
  localparam int G = 2;
`ifdef SPI_ADC_POLLER_AVG_EN
  localparam int        REPS = 4;
  localparam logic [9:0] EXP3 = 10'h101;  // (0x100+0x101+0x102+0x103)/4
`else
  localparam int        REPS = 1;
  localparam logic [9:0] EXP3 = 10'h100;
`endif

  logic clk, rst;
  logic stub_rdy, stub_dv, hold, inj_dv;
  logic [7:0] stub_byte, inj_byte;
  int n_cmp = 0, n_err = 0;
  int tx_cnt = 0, samp_cnt = 0, cs_falls = 0, rst_cnt = 0;
  logic cs_prev = 1'b1;
  logic [7:0]  txq[$];
  logic [7:0]  stubq[$];
  logic [12:0] sampq[$];

  spi_adc_poller_if bus();

  assign bus.tx_ready = stub_rdy & ~hold;
  assign bus.rx_dv    = stub_dv | inj_dv;
  assign bus.rx_byte  = inj_dv ? inj_byte : stub_byte;

  spi_adc_poller #(.c_NUM_CHANNELS(N), .c_POLL_CLKS(P), .c_CS_GAP_CLKS(G)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic push_xact(input logic [2:0] ch, input logic [7:0] b0, b1, b2);
    txq.push_back(8'h01);
    txq.push_back({1'b1, ch, 4'b0000});
    txq.push_back(8'h00);
    stubq.push_back(b0);
    stubq.push_back(b1);
    stubq.push_back(b2);
  endtask

  task automatic wait_tx(input int t);
    for (int k = 0; k < 3000 && tx_cnt < t; k++) @(posedge clk);
    if (tx_cnt < t) timeout("wait_tx");
  endtask

  task automatic wait_samp(input int t);
    for (int k = 0; k < 3000 && samp_cnt < t; k++) @(posedge clk);
    if (samp_cnt < t) timeout("wait_samp");
  endtask

  always @(posedge rst) rst_cnt <= rst_cnt + 1;

  // SPI byte-master stub: busy 4 clocks per byte, answers from stubq.
  initial begin
    int snap;
    stub_rdy = 1; stub_dv = 0; stub_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_dv) begin
        snap = rst_cnt;
        @(posedge clk); #1 stub_rdy = 0;
        repeat (3) @(posedge clk);
        #1;
        if (rst_cnt == snap && !rst) begin
          stub_byte = (stubq.size() != 0) ? stubq.pop_front() : 8'h00;
          stub_dv = 1;
          @(posedge clk); #1 stub_dv = 0;
        end
        stub_rdy = 1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [8:0]  exp_b;
    logic [13:0] exp_s;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cs_prev && !bus.spi_cs_n) cs_falls++;
        if (bus.tx_dv) begin
          exp_b = (txq.size() != 0) ? {1'b0, txq.pop_front()} : 9'h1FF;
          check("tx_byte", {24'd0, bus.tx_byte}, {23'd0, exp_b});
          check("tx_dv_qual", {30'd0, bus.tx_ready, bus.spi_cs_n}, 32'd2);
          tx_cnt++;
        end
        if (bus.sample_dv) begin
          exp_s = (sampq.size() != 0) ? {1'b0, sampq.pop_front()} : 14'h3FFF;
          check("sample", {19'd0, bus.sample_ch, bus.sample}, {18'd0, exp_s});
          samp_cnt++;
        end
      end
      cs_prev = bus.spi_cs_n;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m, base_tx, base_cs;
    bus.enable = 0; hold = 0; inj_dv = 0; inj_byte = 8'h00; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
    check("rst_tx_dv", {31'd0, bus.tx_dv}, 32'd0);
    check("rst_tx_byte", {24'd0, bus.tx_byte}, 32'd0);
    check("rst_sample", {22'd0, bus.sample}, 32'd0);
    check("rst_sample_ch", {29'd0, bus.sample_ch}, 32'd0);
    check("rst_sample_dv", {31'd0, bus.sample_dv}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);

    // Abort mid-frame: reset while waiting on the reply to byte 2 of ch0.
    txq.push_back(8'h01); txq.push_back(8'h80);
    stubq.push_back(8'hFF); stubq.push_back(8'hFE);
    @(negedge clk); rst = 0; bus.enable = 1;
    wait_tx(2);
    #2 rst = 1;
    #1;
    check("abort_cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(posedge clk);
    stubq.delete();

    // Sweep 1: fresh start at 0x01 after release.
    for (int r = 0; r < REPS; r++) push_xact(3'd0, 8'hFF, 8'hFE, 8'h5A);
    for (int r = 0; r < REPS; r++) push_xact(3'd1, 8'h00, 8'h01, 8'h33);
    sampq.push_back({3'd0, 10'h25A});
    sampq.push_back({3'd1, 10'h133});
    @(negedge clk); rst = 0;
    wait_samp(2);

    // Sweep 2 expectations, then poll gap with an RX strobe injected in it.
    for (int r = 0; r < REPS; r++) push_xact(3'd0, 8'h12, 8'hAB, 8'hCD);
    for (int r = 0; r < REPS; r++) push_xact(3'd1, 8'h00, 8'hFD, 8'h07);
    sampq.push_back({3'd0, 10'h3CD});
    sampq.push_back({3'd1, 10'h107});
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 5) begin inj_byte = 8'hEE; inj_dv = 1; end
      if (n == 6) inj_dv = 0;
    end while (bus.spi_cs_n && n < 500);
    check("poll_len", n, P + 1);

    // Stray RX strobe during CS setup; CS fall to first strobe latency.
    inj_byte = 8'h77; inj_dv = 1;
    m = 0;
    do begin
      @(negedge clk); m++;
      if (m == 1) inj_dv = 0;
    end while (!bus.tx_dv && m < 100);
    check("cs_to_txdv", m, G + 1);

    // TX ready held low for 20 clocks in SEND of ch1.
    wait_samp(3);
    #1 hold = 1;
    repeat (24) @(posedge clk);
    @(negedge clk);
    check("hold_tx_dv", {31'd0, bus.tx_dv}, 32'd0);
    check("hold_cs_n", {31'd0, bus.spi_cs_n}, 32'd0);
    @(posedge clk); #1 hold = 0;
    @(negedge clk);
    check("ready_tx_dv", {31'd0, bus.tx_dv}, 32'd1);
    wait_samp(4);

    // Sweep 3: drop enable after byte 2 of ch0 is sent.
    base_tx = tx_cnt;
    base_cs = cs_falls;
    for (int r = 0; r < REPS; r++) push_xact(3'd0, 8'h00, 8'h01, 8'(r));
    sampq.push_back({3'd0, EXP3});
    wait_tx(base_tx + 2);
    #1 bus.enable = 0;
    wait_samp(5);
    repeat (40) @(negedge clk);
    check("drop_busy", {31'd0, bus.busy}, 32'd0);
    check("drop_cs_n", {31'd0, bus.spi_cs_n}, 32'd1);
    check("drop_cs_pulses", cs_falls - base_cs, REPS);
    check("drop_sample_hold", {22'd0, bus.sample}, {22'd0, EXP3});
    check("txq_left", txq.size(), 0);
    check("sampq_left", sampq.size(), 0);
    check("sample_total", samp_cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
